// File: rtl/id_ex_pipe_if.sv
// id_ex_pipe_if: bus between the ID stage / hazard unit and the ID/EX register.
// The master side (ID stage, hazard unit, bypass sources) drives every i_* signal.
// The slave side (id_ex_pipe) drives every o_* signal.
// There is no valid/ready handshake on this bus.
// The hazard unit stalls the register with i_ex_hold and i_id_ex_halt instead.
// o_bubble_cnt carries data only when ID_EX_BUBBLE_CNT_EN is defined.
interface id_ex_pipe_if #(
    parameter int XLEN = 32,
    parameter int AOPW = 4
);
    logic            i_id_ex_halt;
    logic            i_flush;
    logic            i_ex_hold;
    logic            i_frwd_alu_op1;
    logic            i_frwd_mem_op1;
    logic            i_frwd_alu_op2;
    logic            i_frwd_mem_op2;
    logic            i_id_valid;
    logic [XLEN-1:0] i_id_pc;
    logic [XLEN-1:0] i_id_rs1_data;
    logic [XLEN-1:0] i_id_rs2_data;
    logic [XLEN-1:0] i_id_imm;
    logic [AOPW-1:0] i_id_alu_op;
    logic [4:0]      i_id_rd_waddr;
    logic            i_id_rd_wen;
    logic            i_id_mem_ren;
    logic            i_id_mem_wen;
    logic [XLEN-1:0] i_alu_result;
    logic [XLEN-1:0] i_mem_result;
    logic            o_ex_valid;
    logic [XLEN-1:0] o_ex_pc;
    logic [XLEN-1:0] o_ex_op1;
    logic [XLEN-1:0] o_ex_op2;
    logic [XLEN-1:0] o_ex_imm;
    logic [AOPW-1:0] o_ex_alu_op;
    logic [4:0]      o_ex_rd_waddr;
    logic            o_ex_rd_wen;
    logic            o_ex_mem_ren;
    logic            o_ex_mem_wen;
    logic [31:0]     o_bubble_cnt;

    modport master (
        output i_id_ex_halt, i_flush, i_ex_hold,
        output i_frwd_alu_op1, i_frwd_mem_op1, i_frwd_alu_op2, i_frwd_mem_op2,
        output i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
        output i_id_alu_op, i_id_rd_waddr, i_id_rd_wen, i_id_mem_ren, i_id_mem_wen,
        output i_alu_result, i_mem_result,
        input  o_ex_valid, o_ex_pc, o_ex_op1, o_ex_op2, o_ex_imm, o_ex_alu_op,
        input  o_ex_rd_waddr, o_ex_rd_wen, o_ex_mem_ren, o_ex_mem_wen, o_bubble_cnt
    );

    modport slave (
        input  i_id_ex_halt, i_flush, i_ex_hold,
        input  i_frwd_alu_op1, i_frwd_mem_op1, i_frwd_alu_op2, i_frwd_mem_op2,
        input  i_id_valid, i_id_pc, i_id_rs1_data, i_id_rs2_data, i_id_imm,
        input  i_id_alu_op, i_id_rd_waddr, i_id_rd_wen, i_id_mem_ren, i_id_mem_wen,
        input  i_alu_result, i_mem_result,
        output o_ex_valid, o_ex_pc, o_ex_op1, o_ex_op2, o_ex_imm, o_ex_alu_op,
        output o_ex_rd_waddr, o_ex_rd_wen, o_ex_mem_ren, o_ex_mem_wen, o_bubble_cnt
    );
endinterface

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register plus the EX operand forwarding muxes.
// The register update priority is: reset > flush > hold > halt > load.
// A flush or a halt inserts a bubble: valid, the control bits and the forward flags
// are cleared, and the data fields keep their old values.
// The operand forwarding muxes are combinational and read the registered forward flags.
// Optional macro ID_EX_BUBBLE_CNT_EN enables a counter of halt bubbles on o_bubble_cnt.
// Without the macro, o_bubble_cnt is tied to 0.
module id_ex_pipe #(
    parameter int XLEN = 32,
    parameter int AOPW = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    id_ex_pipe_if.slave  bus
);
    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [XLEN-1:0] imm_q;
    logic [AOPW-1:0] alu_op_q;
    logic [4:0]      rd_waddr_q;
    logic            rd_wen_q;
    logic            mem_ren_q;
    logic            mem_wen_q;
    logic            fa1_q;
    logic            fm1_q;
    logic            fa2_q;
    logic            fm2_q;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            halt_bubble;

    // A halt only creates a bubble when no flush and no hold take priority over it.
    assign halt_bubble = bus.i_id_ex_halt & ~bus.i_flush & ~bus.i_ex_hold;

    // Operand forwarding. The ALU result is the younger producer, so it wins over memory.
    always_comb begin
        op1 = rs1_q;
        op2 = rs2_q;
        if (fa1_q)      op1 = bus.i_alu_result;
        else if (fm1_q) op1 = bus.i_mem_result;
        if (fa2_q)      op2 = bus.i_alu_result;
        else if (fm2_q) op2 = bus.i_mem_result;
    end

    // ID/EX register: apply reset, flush, hold, halt bubble or load in priority order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            imm_q      <= '0;
            alu_op_q   <= '0;
            rd_waddr_q <= '0;
            rd_wen_q   <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
            fa1_q      <= 1'b0;
            fm1_q      <= 1'b0;
            fa2_q      <= 1'b0;
            fm2_q      <= 1'b0;
        end else if (bus.i_flush || halt_bubble) begin
            valid_q   <= 1'b0;
            rd_wen_q  <= 1'b0;
            mem_ren_q <= 1'b0;
            mem_wen_q <= 1'b0;
            fa1_q     <= 1'b0;
            fm1_q     <= 1'b0;
            fa2_q     <= 1'b0;
            fm2_q     <= 1'b0;
        end else if (bus.i_ex_hold) begin
            // Store the forwarded value now, because the producer may move on
            // while this instruction is stalled.
            if (fa1_q || fm1_q) rs1_q <= op1;
            if (fa2_q || fm2_q) rs2_q <= op2;
            fa1_q <= 1'b0;
            fm1_q <= 1'b0;
            fa2_q <= 1'b0;
            fm2_q <= 1'b0;
        end else begin
            valid_q    <= bus.i_id_valid;
            pc_q       <= bus.i_id_pc;
            rs1_q      <= bus.i_id_rs1_data;
            rs2_q      <= bus.i_id_rs2_data;
            imm_q      <= bus.i_id_imm;
            alu_op_q   <= bus.i_id_alu_op;
            rd_waddr_q <= bus.i_id_rd_waddr;
            rd_wen_q   <= bus.i_id_rd_wen  & bus.i_id_valid;
            mem_ren_q  <= bus.i_id_mem_ren & bus.i_id_valid;
            mem_wen_q  <= bus.i_id_mem_wen & bus.i_id_valid;
            fa1_q      <= bus.i_frwd_alu_op1;
            fm1_q      <= bus.i_frwd_mem_op1;
            fa2_q      <= bus.i_frwd_alu_op2;
            fm2_q      <= bus.i_frwd_mem_op2;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_q;

    // Count the halt bubbles. Flushes are not counted, and the counter wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst)            bubble_cnt_q <= '0;
        else if (halt_bubble) bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end

    assign bus.o_bubble_cnt = bubble_cnt_q;
`else
    assign bus.o_bubble_cnt = 32'd0;
`endif

    assign bus.o_ex_valid    = valid_q;
    assign bus.o_ex_pc       = pc_q;
    assign bus.o_ex_op1      = op1;
    assign bus.o_ex_op2      = op2;
    assign bus.o_ex_imm      = imm_q;
    assign bus.o_ex_alu_op   = alu_op_q;
    assign bus.o_ex_rd_waddr = rd_waddr_q;
    assign bus.o_ex_rd_wen   = rd_wen_q  & valid_q;
    assign bus.o_ex_mem_ren  = mem_ren_q & valid_q;
    assign bus.o_ex_mem_wen  = mem_wen_q & valid_q;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: self-checking bench for id_ex_pipe.
// Expected EX states are pushed to exp_q when stimulus is driven and popped after the edge.
// The bench tracks the expected bubble count according to ID_EX_BUBBLE_CNT_EN.
module tb_id_ex_pipe;
    localparam int XLEN = 32;
    localparam int AOPW = 4;
    localparam int W    = 1 + 4*XLEN + AOPW + 5 + 3;

    typedef struct {
        logic            halt, flush, hold, valid;
        logic [XLEN-1:0] pc, rs1, rs2, imm;
        logic [AOPW-1:0] aop;
        logic [4:0]      rd;
        logic            wen, ren, mwen;
        logic            fa1, fm1, fa2, fm2;
        logic [XLEN-1:0] alu, mem;
        logic [W-1:0]    exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic [31:0]  exp_bub;
    logic [W-1:0] exp_q[$];
    vec_t         tbl[6];
    vec_t         v;

    id_ex_pipe_if #(.XLEN(XLEN), .AOPW(AOPW)) bus ();

    id_ex_pipe #(.XLEN(XLEN), .AOPW(AOPW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [W-1:0] pk(logic vv, logic [XLEN-1:0] pc, logic [XLEN-1:0] o1,
                                        logic [XLEN-1:0] o2, logic [XLEN-1:0] imm,
                                        logic [AOPW-1:0] aop, logic [4:0] rd,
                                        logic wen, logic ren, logic mwen);
        return {vv, pc, o1, o2, imm, aop, rd, wen, ren, mwen};
    endfunction

    function automatic vec_t ld(logic [XLEN-1:0] pc, logic [XLEN-1:0] rs1, logic [XLEN-1:0] rs2,
                                logic [XLEN-1:0] imm, logic [AOPW-1:0] aop, logic [4:0] rd,
                                logic vv, logic wen, logic ren, logic mwen,
                                logic fa1, logic fm1, logic fa2, logic fm2,
                                logic [XLEN-1:0] alu, logic [XLEN-1:0] mem);
        vec_t r;
        r.halt = 1'b0; r.flush = 1'b0; r.hold = 1'b0; r.valid = vv;
        r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm; r.aop = aop; r.rd = rd;
        r.wen = wen; r.ren = ren; r.mwen = mwen;
        r.fa1 = fa1; r.fm1 = fm1; r.fa2 = fa2; r.fm2 = fm2;
        r.alu = alu; r.mem = mem; r.exp = '0;
        return r;
    endfunction

    function automatic logic [W-1:0] actual();
        return pk(bus.o_ex_valid, bus.o_ex_pc, bus.o_ex_op1, bus.o_ex_op2, bus.o_ex_imm,
                  bus.o_ex_alu_op, bus.o_ex_rd_waddr, bus.o_ex_rd_wen, bus.o_ex_mem_ren,
                  bus.o_ex_mem_wen);
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic check_bub(input string name);
        total++;
        if (bus.o_bubble_cnt !== exp_bub) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, bus.o_bubble_cnt, exp_bub);
        end
    endtask

    task automatic drive(input vec_t d);
        bus.i_id_ex_halt   = d.halt;
        bus.i_flush        = d.flush;
        bus.i_ex_hold      = d.hold;
        bus.i_id_valid     = d.valid;
        bus.i_id_pc        = d.pc;
        bus.i_id_rs1_data  = d.rs1;
        bus.i_id_rs2_data  = d.rs2;
        bus.i_id_imm       = d.imm;
        bus.i_id_alu_op    = d.aop;
        bus.i_id_rd_waddr  = d.rd;
        bus.i_id_rd_wen    = d.wen;
        bus.i_id_mem_ren   = d.ren;
        bus.i_id_mem_wen   = d.mwen;
        bus.i_frwd_alu_op1 = d.fa1;
        bus.i_frwd_mem_op1 = d.fm1;
        bus.i_frwd_alu_op2 = d.fa2;
        bus.i_frwd_mem_op2 = d.fm2;
        bus.i_alu_result   = d.alu;
        bus.i_mem_result   = d.mem;
    endtask

    // Drive one vector, queue its expectation, then compare after the edge.
    task automatic step(input string name, input vec_t d);
        logic [W-1:0] e;
        drive(d);
        exp_q.push_back(d.exp);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(name, actual(), e);
    endtask

    task automatic add_bubble();
`ifdef ID_EX_BUBBLE_CNT_EN
        exp_bub = exp_bub + 32'd1;
`endif
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        exp_bub = '0;

        tbl[0] = ld(32'h100, 32'd5, 32'd7, 32'h10, 4'd2, 5'd3, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        tbl[0].exp = pk(1, 32'h100, 32'd5, 32'd7, 32'h10, 4'd2, 5'd3, 1, 0, 0);
        tbl[1] = ld(32'h104, 32'd1, 32'd2, 32'h20, 4'd5, 5'd4, 1, 1, 0, 0, 1, 1, 0, 0, 32'hAA, 32'hBB);
        tbl[1].exp = pk(1, 32'h104, 32'hAA, 32'd2, 32'h20, 4'd5, 5'd4, 1, 0, 0);
        tbl[2] = ld(32'h108, 32'd11, 32'd12, 32'h30, 4'd7, 5'd9, 0, 1, 1, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        tbl[2].exp = pk(0, 32'h108, 32'd11, 32'd12, 32'h30, 4'd7, 5'd9, 0, 0, 0);
        tbl[3] = ld(32'h10C, 32'd13, 32'd9, 32'h40, 4'd1, 5'd0, 1, 0, 0, 1, 0, 0, 0, 1, 32'h1, 32'h77);
        tbl[3].exp = pk(1, 32'h10C, 32'd13, 32'h77, 32'h40, 4'd1, 5'd0, 0, 0, 1);
        tbl[4] = ld(32'h110, 32'd21, 32'd22, 32'h50, 4'hF, 5'd31, 1, 1, 0, 0, 0, 1, 1, 1, 32'h123, 32'h456);
        tbl[4].exp = pk(1, 32'h110, 32'h456, 32'h123, 32'h50, 4'hF, 5'd31, 1, 0, 0);
        tbl[5] = ld(32'h114, 32'd31, 32'd32, 32'h60, 4'd3, 5'd5, 1, 1, 1, 0, 0, 0, 0, 0, 32'hDEAD, 32'hBEEF);
        tbl[5].exp = pk(1, 32'h114, 32'd31, 32'd32, 32'h60, 4'd3, 5'd5, 1, 1, 0);

        // Reset.
        v = ld(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(v);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_outputs", actual(), '0);
        check_bub("reset_bubble_cnt");

        // Table-driven loads.
        for (int i = 0; i < 6; i++) step($sformatf("table_%0d", i), tbl[i]);

        // Forwarding: the ALU result wins, and op1 follows i_alu_result in the same cycle.
        v = ld(32'h200, 32'd1, 32'd2, 32'd4, 4'd1, 5'd6, 1, 1, 0, 0, 1, 1, 0, 0, 32'hAA, 32'hBB);
        v.exp = pk(1, 32'h200, 32'hAA, 32'd2, 32'd4, 4'd1, 5'd6, 1, 0, 0);
        step("fwd_alu_prio", v);
        bus.i_alu_result = 32'hCC;
        #1;
        check("fwd_live", {{(W-XLEN){1'b0}}, bus.o_ex_op1}, {{(W-XLEN){1'b0}}, 32'hCC});

        // Hold keeps the forwarded op2, even after the memory result changes.
        v = ld(32'h300, 32'd3, 32'd3, 32'd8, 4'd2, 5'd7, 1, 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h55);
        v.exp = pk(1, 32'h300, 32'd3, 32'h55, 32'd8, 4'd2, 5'd7, 1, 0, 0);
        step("hold_load", v);
        v.hold = 1'b1; v.pc = 32'h304; v.rs2 = 32'h66; v.fm2 = 1'b0;
        step("hold_edge1", v);
        bus.i_mem_result = 32'h99;
        #1;
        check("hold_mem_change", {{(W-XLEN){1'b0}}, bus.o_ex_op2}, {{(W-XLEN){1'b0}}, 32'h55});
        v.halt = 1'b1; v.mem = 32'h99;
        step("hold_edge2_halt_ignored", v);
        check_bub("hold_no_bubble");

        // Two back-to-back halts with a valid store in ID, then release.
        v = ld(32'h400, 32'd41, 32'd42, 32'd9, 4'd4, 5'd8, 1, 0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0);
        v.halt = 1'b1;
        v.exp = pk(0, 32'h300, 32'd3, 32'h55, 32'd8, 4'd2, 5'd7, 0, 0, 0);
        step("halt_1", v);
        add_bubble();
        step("halt_2", v);
        add_bubble();
        check_bub("halt_bubble_cnt");
        v.halt = 1'b0;
        v.exp = pk(1, 32'h400, 32'd41, 32'd42, 32'd9, 4'd4, 5'd8, 0, 0, 1);
        step("halt_release", v);

        // A flush with hold squashes the valid EX instruction and is not counted.
        v = ld(32'h500, 32'd51, 32'd52, 32'd1, 4'd9, 5'd2, 1, 1, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
        v.flush = 1'b1; v.hold = 1'b1;
        v.exp = pk(0, 32'h400, 32'd41, 32'd42, 32'd9, 4'd4, 5'd8, 0, 0, 0);
        step("flush_over_hold", v);
        check_bub("flush_not_counted");

        // Reset during hold, then a normal load.
        v = ld(32'h600, 32'd61, 32'd62, 32'd3, 4'd6, 5'd10, 1, 1, 0, 0, 1, 0, 0, 0, 32'h777, 32'h888);
        v.exp = pk(1, 32'h600, 32'h777, 32'd62, 32'd3, 4'd6, 5'd10, 1, 0, 0);
        step("pre_reset_load", v);
        v.hold = 1'b1;
        v.exp = '0;
        rst = 1'b1;
        step("reset_in_hold", v);
        rst = 1'b0;
        exp_bub = '0;
        check_bub("reset_in_hold_cnt");
        v = ld(32'h700, 32'd71, 32'd72, 32'd5, 4'd8, 5'd12, 1, 0, 1, 0, 0, 0, 0, 0, 32'h1, 32'h2);
        v.exp = pk(1, 32'h700, 32'd71, 32'd72, 32'd5, 4'd8, 5'd12, 0, 1, 0);
        step("post_reset_load", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
ID/EX pipeline register and EX operand-supply stage. It consumes the stall and forwarding controls of the hazard detection unit.
- Captures decoded instruction fields from ID.
- Inserts bubbles on halt or flush.
- Holds state during downstream stalls.
- Presents final EX operands after applying ALU/memory result forwarding.
- Sits between the decoder/register file and the ALU.

Parameters:
XLEN, 32, datapath width of PC, operands and immediate
AOPW, 4, width of ALU opcode field

Ports:
i_clk  in  1  global clock
i_rst  in  1  global reset, synchronous, active-high
i_id_ex_halt  in  1  hazard halt; insert bubble into ID/EX
i_flush  in  1  branch/jump squash of ID/EX
i_ex_hold  in  1  downstream stall; hold ID/EX contents
i_frwd_alu_op1  in  1  forward ALU result to op1 for incoming instruction
i_frwd_mem_op1  in  1  forward memory result to op1
i_frwd_alu_op2  in  1  forward ALU result to op2
i_frwd_mem_op2  in  1  forward memory result to op2
i_id_valid  in  1  ID holds a real instruction
i_id_pc  in  XLEN  instruction PC
i_id_rs1_data  in  XLEN  register-file read data 1
i_id_rs2_data  in  XLEN  register-file read data 2
i_id_imm  in  XLEN  decoded immediate
i_id_alu_op  in  AOPW  ALU operation
i_id_rd_waddr  in  5  destination register
i_id_rd_wen  in  1  register write enable
i_id_mem_ren  in  1  load
i_id_mem_wen  in  1  store
i_alu_result  in  XLEN  result currently at ALU output (EX/MEM)
i_mem_result  in  XLEN  result currently at memory output (MEM/WB)
o_ex_valid  out  1  EX instruction valid
o_ex_pc  out  XLEN  registered PC
o_ex_op1  out  XLEN  final operand 1 after forwarding
o_ex_op2  out  XLEN  final operand 2 after forwarding
o_ex_imm  out  XLEN  registered immediate
o_ex_alu_op  out  AOPW  registered ALU op
o_ex_rd_waddr  out  5  registered destination
o_ex_rd_wen  out  1  qualified write enable (0 when invalid)
o_ex_mem_ren  out  1  qualified load
o_ex_mem_wen  out  1  qualified store
o_bubble_cnt  out  32  bubble counter (optional feature)

Behaviour:
- Reset (i_rst sampled high at a clock edge):
  - All registers cleared; every output 0.
  - Forward flags cleared.
  - Reset mid-operation discards the held instruction.
- Update priority per rising edge: i_rst > i_flush > i_ex_hold > i_id_ex_halt > load.
- Flush: valid, rd_wen, mem_ren, mem_wen and forward flags cleared. Data fields don't care (left unchanged). Applies even while i_ex_hold is high.
- Hold (no flush):
  - All fields retained.
  - For each operand whose ALU or memory forward flag is set, the currently selected forwarded value is written into that operand register and the flag is cleared. This keeps the forwarded value when the producer advances.
  - i_id_ex_halt is ignored during hold.
- Halt (no flush/hold): bubble inserted exactly as for flush. ID contents are not captured; IF/ID is held upstream.
- Load: all ID fields captured.
  - valid = i_id_valid.
  - Control bits are ANDed with i_id_valid.
  - The four forward flags are captured with the instruction.
- Forwarding (combinational from registered state, per operand):
  - ALU flag set -> i_alu_result.
  - Else memory flag set -> i_mem_result.
  - Else the registered register-file data.
  - If both flags are set, ALU wins (younger producer).
  - op1 and op2 are selected independently.
- Output latency: one cycle from ID capture to registered outputs. Operand outputs follow forwarding inputs with zero cycles.
- Control outputs are always 0 when o_ex_valid = 0.
- Back-to-back halts produce one bubble per cycle. Halt releasing loads the held ID instruction on the next edge.

Optional Feature:
ID_EX_BUBBLE_CNT_EN
- Defined: o_bubble_cnt is a 32-bit counter.
  - Cleared on reset.
  - Increments by 1 on each edge where a halt bubble is inserted (halt taken, no flush/hold).
  - Wraps 0xFFFFFFFF -> 0.
  - Flushes are not counted.
- Undefined: no counter logic; o_bubble_cnt tied to 0.

Test Plan:
- Reset then load pc=0x100, rs1=5, rs2=7, rd=3, rd_wen=1, no forwards -> next cycle o_ex_op1=5, o_ex_op2=7, o_ex_rd_waddr=3, o_ex_rd_wen=1, o_ex_valid=1.
- Load with i_frwd_alu_op1=1, i_frwd_mem_op1=1, i_alu_result=0xAA, i_mem_result=0xBB -> o_ex_op1=0xAA (ALU priority); change i_alu_result to 0xCC -> o_ex_op1=0xCC same cycle.
- Load with i_frwd_mem_op2=1, i_mem_result=0x55, then i_ex_hold=1 for 2 cycles while i_mem_result changes to 0x99 after the first held edge -> o_ex_op2 stays 0x55.
- i_id_ex_halt=1 for 2 cycles with valid ID store -> o_ex_valid=0 and o_ex_mem_wen=0 for 2 cycles; with ID_EX_BUBBLE_CNT_EN, o_bubble_cnt=2.
- i_flush=1 and i_ex_hold=1 together with a valid EX instruction -> o_ex_valid=0 next cycle; o_bubble_cnt unchanged.
- i_rst asserted during i_ex_hold with a valid instruction -> all outputs 0 next cycle; first load after deassert behaves normally.
